// File: rtl/div_scheduler_pkg.sv
// Shared types and constants for the divider scheduler slice.
package div_sched_pkg;
   localparam int DIV_W = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/div_scheduler_if.sv
// Scheduler-to-divider bus; master = scheduler, slave = divider.
interface div_scheduler_if
   import div_sched_pkg::*;
#(
   parameter int W = DIV_W
);
   // Handshake: div_start is a one-cycle launch pulse issued only while div_busy is low;
   // div_a/div_b stay stable until the op ends with a one-cycle div_valid, div_dvz or div_ovf.
   logic         div_start;
   logic         div_sclr;
   logic [W-1:0] div_a;
   logic [W-1:0] div_b;
   logic         div_busy;
   logic         div_valid;
   logic         div_dvz;
   logic         div_ovf;
   logic [W-1:0] div_q;

   modport master (
      output div_start, div_sclr, div_a, div_b,
      input  div_busy, div_valid, div_dvz, div_ovf, div_q
   );

   modport slave (
      input  div_start, div_sclr, div_a, div_b,
      output div_busy, div_valid, div_dvz, div_ovf, div_q
   );
endinterface

// File: rtl/div_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);
   logic          hit_hi;
   logic          hit_lo;
   logic [IW-1:0] idx_hi;
   logic [IW-1:0] idx_lo;

   // Descending scan leaves the lowest index in each half: at/after the pointer, and before it.
   always_comb begin
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      idx_hi = '0;
      idx_lo = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (i >= int'(rr_ptr)) begin
               hit_hi = 1'b1;
               idx_hi = IW'(i);
            end else begin
               hit_lo = 1'b1;
               idx_lo = IW'(i);
            end
         end
      end
      idx = hit_hi ? idx_hi : idx_lo;
      gnt = '0;
      if (hit_hi || hit_lo) gnt[idx] = 1'b1;
   end
endmodule

// File: rtl/div_scheduler.sv
// Shares one divider among N_REQ requesters, round-robin, one op at a time.
// Optional watchdog abort enabled by defining DIV_SCHED_TIMEOUT_EN.
module div_scheduler
   import div_sched_pkg::*;
#(
   parameter int  N_REQ   = 4,
   parameter int  W       = DIV_W,
   parameter int  TIMEOUT = 255,
   localparam int IW      = clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   gnt,
   output logic               rsp_valid,
   output logic [IW-1:0]      rsp_id,
   output logic [W-1:0]       rsp_q,
   output logic               rsp_dvz,
   output logic               rsp_ovf,
   output logic               rsp_err,
   div_scheduler_if.master    div,
   output state_t             state_dbg
);
   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("div_scheduler: N_REQ must be 2..8 and TIMEOUT at least 1");
   end

   state_t         state;
   logic [IW-1:0]  rr_ptr;
   logic [IW-1:0]  id;
   logic [W-1:0]   q_r;
   logic           dvz_r;
   logic           ovf_r;
   logic [N_REQ-1:0] arb_gnt;
   logic [IW-1:0]  arb_idx;

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
      .req    (req),
      .rr_ptr (rr_ptr),
      .gnt    (arb_gnt),
      .idx    (arb_idx)
   );

   assign state_dbg = state;

`ifdef DIV_SCHED_TIMEOUT_EN
   localparam int CW = clog2(TIMEOUT + 1);
   logic [CW-1:0] wd_cnt;
   logic          err_r;
`else
   assign rsp_err      = 1'b0;
   assign div.div_sclr = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         id            <= '0;
         q_r           <= '0;
         dvz_r         <= 1'b0;
         ovf_r         <= 1'b0;
         gnt           <= '0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_q         <= '0;
         rsp_dvz       <= 1'b0;
         rsp_ovf       <= 1'b0;
         div.div_start <= 1'b0;
         div.div_a     <= '0;
         div.div_b     <= '0;
`ifdef DIV_SCHED_TIMEOUT_EN
         wd_cnt        <= '0;
         err_r         <= 1'b0;
         rsp_err       <= 1'b0;
         div.div_sclr  <= 1'b0;
`endif
      end else begin
         gnt           <= '0;
         rsp_valid     <= 1'b0;
         div.div_start <= 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
         div.div_sclr  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt       <= arb_gnt;
                  id        <= arb_idx;
                  div.div_a <= req_a[arb_idx*W +: W];
                  div.div_b <= req_b[arb_idx*W +: W];
                  state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (!div.div_busy) begin
                  div.div_start <= 1'b1;
                  state         <= WAIT;
`ifdef DIV_SCHED_TIMEOUT_EN
                  wd_cnt        <= '0;
`endif
               end
            end
            WAIT: begin
               // Exception flags end the op too; the quotient is meaningless then.
               if (div.div_valid || div.div_dvz || div.div_ovf) begin
                  q_r   <= (div.div_dvz || div.div_ovf) ? '0 : div.div_q;
                  dvz_r <= div.div_dvz;
                  ovf_r <= div.div_ovf;
                  state <= RESP;
`ifdef DIV_SCHED_TIMEOUT_EN
                  err_r <= 1'b0;
               end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                  div.div_sclr <= 1'b1;
                  q_r          <= '0;
                  dvz_r        <= 1'b0;
                  ovf_r        <= 1'b0;
                  err_r        <= 1'b1;
                  state        <= RESP;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
`endif
               end
            end
            RESP: begin
               rsp_valid <= 1'b1;
               rsp_id    <= id;
               rsp_q     <= q_r;
               rsp_dvz   <= dvz_r;
               rsp_ovf   <= ovf_r;
`ifdef DIV_SCHED_TIMEOUT_EN
               rsp_err   <= err_r;
`endif
               rr_ptr    <= (id == IW'(N_REQ - 1)) ? '0 : id + 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural divider model.
// Define DIV_SCHED_TIMEOUT_EN to also exercise the watchdog abort.
module tb_div_scheduler;
   import div_sched_pkg::*;

   localparam int N  = 4;
   localparam int W  = 10;
   localparam int IW = 2;
`ifdef DIV_SCHED_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   gnt;
   logic           rsp_valid;
   logic [IW-1:0]  rsp_id;
   logic [W-1:0]   rsp_q;
   logic           rsp_dvz;
   logic           rsp_ovf;
   logic           rsp_err;
   state_t         state_dbg;

   div_scheduler_if #(.W(W)) dif ();

   div_scheduler #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_a     (req_a),
      .req_b     (req_b),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_q     (rsp_q),
      .rsp_dvz   (rsp_dvz),
      .rsp_ovf   (rsp_ovf),
      .rsp_err   (rsp_err),
      .div       (dif.master),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- divider model: result lat cycles after the start cycle
   int         lat = 3;
   logic       hang = 1'b0;
   logic       force_ovf = 1'b0;
   logic       pending = 1'b0;
   int         mcnt = 0;
   logic [W-1:0] ma, mb;

   always @(negedge clk) begin
      dif.div_valid = 1'b0;
      dif.div_dvz   = 1'b0;
      dif.div_ovf   = 1'b0;
      if (!rst_n || dif.div_sclr) begin
         pending = 1'b0;
      end else if (dif.div_start) begin
         pending = 1'b1;
         mcnt    = lat;
         ma      = dif.div_a;
         mb      = dif.div_b;
      end else if (pending) begin
         mcnt = mcnt - 1;
         if (mcnt <= 0 && !hang) begin
            pending = 1'b0;
            if (mb == '0) begin
               dif.div_dvz = 1'b1;
               dif.div_q   = '1;
            end else if (force_ovf) begin
               dif.div_ovf = 1'b1;
               dif.div_q   = '1;
            end else begin
               dif.div_valid = 1'b1;
               dif.div_q     = ma / mb;
            end
         end
      end
   end

   // ---------------- event monitor
   int start_cnt = 0, start_cyc = 0, rsp_cnt = 0, sclr_cnt = 0, sclr_cyc = 0;
   always @(negedge clk) begin
      if (dif.div_start) begin
         start_cnt = start_cnt + 1;
         start_cyc = cyc;
      end
      if (dif.div_sclr) begin
         sclr_cnt = sclr_cnt + 1;
         sclr_cyc = cyc;
      end
      if (rsp_valid) rsp_cnt = rsp_cnt + 1;
   end

   // ---------------- scoreboard
   int total = 0;
   int bad = 0;
   logic [IW+W+2:0] exp_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      total++;
      if (act !== req_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req_v, cyc);
      end
   endtask

   function automatic void exp_push(input int id, input logic [W-1:0] q,
                                    input logic dvz, input logic ovf, input logic err);
      exp_q.push_back({IW'(id), q, dvz, ovf, err});
   endfunction

   task automatic wait_gnt(output logic [N-1:0] g, output int gc);
      g  = '0;
      gc = -1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (gnt != '0) begin
            g  = gnt;
            gc = cyc;
            break;
         end
      end
      if (gc < 0) begin
         total++;
         bad++;
         $display("FAIL gnt_wait: no grant in 100 cycles, required one");
      end
   endtask

   task automatic wait_rsp(output int rc);
      logic [IW+W+2:0] e;
      rc = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (rsp_valid) begin
            rc = cyc;
            break;
         end
      end
      total++;
      if (rc < 0 || exp_q.size() == 0) begin
         bad++;
         $display("FAIL rsp_wait: response seen=%0d, expected entries=%0d", rc >= 0, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         check("rsp_id",  rsp_id,  e[IW+W+2 -: IW]);
         check("rsp_q",   rsp_q,   e[W+2 -: W]);
         check("rsp_dvz", rsp_dvz, e[2]);
         check("rsp_ovf", rsp_ovf, e[1]);
         check("rsp_err", rsp_err, e[0]);
      end
   endtask

   task automatic check_outputs_zero(input string nm);
      check({nm, "_outs"}, {gnt, rsp_valid, rsp_id, rsp_q, rsp_dvz, rsp_ovf, rsp_err,
                            dif.div_start, dif.div_sclr}, 32'd0);
      check({nm, "_div_ab"}, {dif.div_a, dif.div_b}, 32'd0);
      check({nm, "_state"}, state_dbg, IDLE);
   endtask

   // One isolated op with timing checks; busy_n = cycles div_busy is held in LAUNCH.
   task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic f_ovf, input logic [W-1:0] eq, input logic edvz,
                        input logic eovf, input int busy_n);
      logic [N-1:0] g;
      int gc, rc, s0;
      force_ovf = f_ovf;
      s0 = start_cnt;
      @(negedge clk);
      if (busy_n > 0) dif.div_busy = 1'b1;
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      req[id] = 1'b1;
      exp_push(id, eq, edvz, eovf, 1'b0);
      wait_gnt(g, gc);
      req[id] = 1'b0;
      check("gnt_onehot", g, 32'(1 << id));
      if (busy_n > 0) begin
         repeat (busy_n) @(negedge clk);
         dif.div_busy = 1'b0;
      end
      wait_rsp(rc);
      check("start_count", start_cnt - s0, 1);
      check("start_delay", start_cyc - gc, 1 + busy_n);
      check("rsp_latency", rc - gc, lat + 3 + busy_n);
      force_ovf = 1'b0;
   endtask

   typedef struct {
      int           id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         f_ovf;
      logic [W-1:0] q;
      logic         dvz;
      logic         ovf;
      int           busy_n;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [N-1:0] g;
      int gc, rc, r0;

      vecs[0] = '{2, 10'd100,  10'd7,  1'b0, 10'd14,   1'b0, 1'b0, 0};
      vecs[1] = '{1, 10'd1000, 10'd10, 1'b0, 10'd100,  1'b0, 1'b0, 0};
      vecs[2] = '{3, 10'd55,   10'd0,  1'b0, 10'd0,    1'b1, 1'b0, 0};
      vecs[3] = '{0, 10'd1023, 10'd1,  1'b0, 10'd1023, 1'b0, 1'b0, 5};
      vecs[4] = '{2, 10'd7,    10'd9,  1'b0, 10'd0,    1'b0, 1'b0, 0};
      vecs[5] = '{1, 10'd500,  10'd3,  1'b1, 10'd0,    1'b0, 1'b1, 0};
      vecs[6] = '{3, 10'd500,  10'd3,  1'b0, 10'd166,  1'b0, 1'b0, 0};

      req = '0;
      req_a = '0;
      req_b = '0;
      dif.div_busy = 1'b0;

      // ---- reset state
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      // ---- all four requesting from reset: order 0,1,2,3
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = W'(100 + i);
         req_b[i*W +: W] = W'(i + 1);
      end
      exp_push(0, 10'd100, 1'b0, 1'b0, 1'b0);
      exp_push(1, 10'd50,  1'b0, 1'b0, 1'b0);
      exp_push(2, 10'd34,  1'b0, 1'b0, 1'b0);
      exp_push(3, 10'd25,  1'b0, 1'b0, 1'b0);
      exp_push(0, 10'd3,   1'b0, 1'b0, 1'b0);
      req = '1;
      rc = 0;
      for (int k = 0; k < N; k++) begin
         wait_gnt(g, gc);
         check("rr_order", g, 32'(1 << k));
         if (k > 0) check("rr_throughput", gc - rc, 1);
         req[k] = 1'b0;
         if (k == N - 1) begin
            // requester 0 comes back while 3 is in flight
            repeat (2) @(negedge clk);
            req_a[0 +: W] = 10'd9;
            req_b[0 +: W] = 10'd3;
            req[0] = 1'b1;
         end
         wait_rsp(rc);
      end
      wait_gnt(g, gc);
      check("rr_wrap", g, 32'b0001);
      check("rr_wrap_throughput", gc - rc, 1);
      req[0] = 1'b0;
      wait_rsp(rc);

      // ---- pointer is now 1: requests 0 and 2 resolve 2 first
      @(negedge clk);
      req_a[0 +: W] = 10'd40;  req_b[0 +: W] = 10'd8;
      req_a[2*W +: W] = 10'd81; req_b[2*W +: W] = 10'd9;
      exp_push(2, 10'd9, 1'b0, 1'b0, 1'b0);
      exp_push(0, 10'd5, 1'b0, 1'b0, 1'b0);
      req = 4'b0101;
      wait_gnt(g, gc);
      check("rr_skip", g, 32'b0100);
      req[2] = 1'b0;
      wait_rsp(rc);
      wait_gnt(g, gc);
      check("rr_skip_next", g, 32'b0001);
      req[0] = 1'b0;
      wait_rsp(rc);

      // ---- table of isolated ops
      for (int i = 0; i < 7; i++)
         do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].f_ovf, vecs[i].q,
               vecs[i].dvz, vecs[i].ovf, vecs[i].busy_n);

      // ---- reset in WAIT abandons the op; pointer returns to 0
      do_op(2, 10'd21, 10'd7, 1'b0, 10'd3, 1'b0, 1'b0, 0);
      hang = 1'b1;
      @(negedge clk);
      req_a[3*W +: W] = 10'd300;
      req_b[3*W +: W] = 10'd3;
      req[3] = 1'b1;
      wait_gnt(g, gc);
      req[3] = 1'b0;
      for (int n = 0; n < 20 && state_dbg != WAIT; n++) @(negedge clk);
      check("reached_wait", state_dbg, WAIT);
      repeat (2) @(negedge clk);
      r0 = rsp_cnt;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      repeat (3) @(negedge clk);
      check("no_rsp_after_rst", rsp_cnt - r0, 0);
      rst_n = 1'b1;
      hang = 1'b0;
      @(negedge clk);
      req_a[1*W +: W] = 10'd1000; req_b[1*W +: W] = 10'd10;
      req_a[3*W +: W] = 10'd90;   req_b[3*W +: W] = 10'd9;
      exp_push(1, 10'd100, 1'b0, 1'b0, 1'b0);
      exp_push(3, 10'd10,  1'b0, 1'b0, 1'b0);
      req = 4'b1010;
      wait_gnt(g, gc);
      check("post_rst_ptr", g, 32'b0010);
      req[1] = 1'b0;
      wait_rsp(rc);
      wait_gnt(g, gc);
      check("post_rst_next", g, 32'b1000);
      req[3] = 1'b0;
      wait_rsp(rc);

`ifdef DIV_SCHED_TIMEOUT_EN
      // ---- divider never answers: watchdog aborts after TO WAIT cycles
      begin
         int sc0;
         sc0 = sclr_cnt;
         hang = 1'b1;
         @(negedge clk);
         req_a[0 +: W] = 10'd5;
         req_b[0 +: W] = 10'd1;
         req[0] = 1'b1;
         exp_push(0, 10'd0, 1'b0, 1'b0, 1'b1);
         wait_gnt(g, gc);
         req[0] = 1'b0;
         wait_rsp(rc);
         hang = 1'b0;
         check("sclr_count", sclr_cnt - sc0, 1);
         check("sclr_delay", sclr_cyc - start_cyc, TO);
         check("err_rsp_delay", rc - sclr_cyc, 1);
      end
`else
      check("sclr_never", sclr_cnt, 0);
`endif

      check("exp_q_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/div_scheduler.md
# div_scheduler

Shares one 10-bit divider among `N_REQ` requesters.
- Requesters are picked round-robin; one operand pair is captured per grant.
- The block sequences the divider's `start`/`valid`/`dvz`/`ovf` handshake.
- The result and status flags go back to the granted requester, tagged with its ID.
- It sits between client blocks and the divider, and is the only block that drives divider `start` and `sclr`.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `W`, 10, operand/quotient width; must match divider
- `TIMEOUT`, 255, watchdog limit in cycles (used only with the macro)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req`  in  N_REQ  per-requester request, level
- `req_a`  in  N_REQ*W  dividends, slice i belongs to requester i
- `req_b`  in  N_REQ*W  divisors, slice i belongs to requester i
- `gnt`  out  N_REQ  one-hot grant pulse; operands captured on this cycle
- `rsp_valid`  out  1  one-cycle result strobe
- `rsp_id`  out  clog2(N_REQ)  requester the result belongs to
- `rsp_q`  out  W  quotient
- `rsp_dvz`, `rsp_ovf`, `rsp_err`  out  1 each  divide-by-zero, overflow, timeout abort
- `div_start`, `div_sclr`  out  1 each  divider controls
- `div_a`, `div_b`  out  W each  divider operands, held from LAUNCH until the op completes
- `div_busy`, `div_valid`, `div_dvz`, `div_ovf`  in  1 each  divider status
- `div_q`  in  W  divider quotient

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - If `req != 0`: the arbiter picks the first set bit at or after `rr_ptr`, wrapping around.
  - Captures `req_a`/`req_b` slice, latches `id`, pulses `gnt[id]`, goes to LAUNCH.
  - If `req == 0`: stays in IDLE.
- **LAUNCH**
  - While `div_busy == 1`: holds and does not assert `div_start`.
  - Otherwise: asserts `div_start` for exactly one cycle, goes to WAIT.
- **WAIT**
  - On `div_valid`, or on `div_dvz`, or on `div_ovf`: captures `div_q`, `div_dvz`, `div_ovf`, goes to RESP.
  - `rsp_q` is forced to 0 when `dvz` or `ovf` is set.
- **RESP**
  - Drives `rsp_valid = 1` for one cycle with the latched `id`, `q` and flags.
  - Sets `rr_ptr = (id+1) mod N_REQ`, returns to IDLE.
- Requester rules:
  - Must hold `req` and operands stable until its `gnt`.
  - Must drop `req` on the cycle after `gnt`; a `req` still high then is a new request.
- Arbiter guarantees:
  - A requester waits at most `N_REQ-1` completed ops.
  - A `req` rising mid-operation is queued, never dropped.
- Reset (`rst_n` low) forces:
  - state IDLE and `rr_ptr = 0`;
  - all outputs 0, including `gnt`, `rsp_*` and `div_*`.
- Reset mid-operation abandons the op; no `rsp_valid` is issued for it.

## Timing
- `gnt` at cycle T; `div_start` at T+1 at the earliest, later by the number of `div_busy` cycles.
- `rsp_valid` is one cycle after the divider status capture.
- Total latency = divider latency + 3 cycles when `div_busy` is low.
- Back-to-back throughput: the next `gnt` is issued the cycle after `rsp_valid`.
- Arbitration is one request per op; there is no pipelining across ops.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `DIV_SCHED_TIMEOUT_EN`.
- **Defined:** a watchdog counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT`, the block pulses `div_sclr` for one cycle and goes to RESP.
  - RESP then carries `rsp_err = 1`, `rsp_q = 0`, `rsp_dvz = rsp_ovf = 0`.
- **Undefined:** no counter is built; `rsp_err` and `div_sclr` are tied to 0; WAIT waits indefinitely.

## Structure
- Package `div_sched_pkg`:
  - state enum (IDLE/LAUNCH/WAIT/RESP);
  - `DIV_W = 10`;
  - ID-width function `clog2`.
- Sub-module `rr_arbiter`:
  - inputs `req` and `rr_ptr`;
  - outputs a one-hot grant and the encoded index;
  - purely combinational;
  - instantiated once.

## Test plan
- Single request: requester 2, A=100, B=7 → one `gnt[2]` pulse, one `div_start`, `rsp_valid` with `rsp_id=2`, `rsp_q=14`, all flags 0.
- All four requesting at once from reset → grants in order 0,1,2,3. Then 0 re-requests while 3 is in WAIT → next grant is 0, with `rr_ptr` wrapped.
- Divide by zero: A=55, B=0, divider returns `dvz` → `rsp_dvz=1`, `rsp_q=0`, `rsp_id` correct.
- `div_busy` held high for 5 cycles during LAUNCH → `div_start` is delayed exactly 5 cycles, pulses once, and the result is correct.
- `rst_n` asserted in WAIT → all outputs 0 immediately, no `rsp_valid`. After release, a new request for 1000/10 returns `q=100`.
- With `DIV_SCHED_TIMEOUT_EN` and `TIMEOUT=8`, divider never asserts valid → `div_sclr` pulses after 8 WAIT cycles, then `rsp_valid` with `rsp_err=1`, `rsp_q=0`.
